// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/PC unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux: jump beats branch beats sequential; flags non-word-aligned results.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            jump,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc + XLEN'(PC_STEP);

  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = jump_target;
    end else if (PCSrc) begin
      next_pc = branch_target;
    end
  end

  assign misaligned = !is_word_aligned(next_pc[1:0]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and fetch/execute sequencer with misalignment halt.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic            jump,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_out,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [31:0]     retire_count
);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("fetch_pc_unit: RESET_PC must be word-aligned");
  end

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [31:0]     instr_q;
  logic [31:0]     retire_q;
  logic            trap_q;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  next_pc_sel #(
    .XLEN(XLEN)
  ) u_next_pc_sel (
    .jump         (jump),
    .PCSrc        (PCSrc),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .pc           (pc_q),
    .next_pc      (next_pc),
    .misaligned   (next_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
      retire_q  <= '0;
    end else begin
      unique case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // A stalled cycle re-evaluates the redirect inputs on the next cycle.
          if (!stall) begin
            retire_q <= retire_q + 32'd1;
            if (next_misaligned) begin
              trap_q    <= 1'b1;
              trap_pc_q <= next_pc;
              state_q   <= S_HALT;
            end else begin
              pc_q    <= next_pc;
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign imem_req        = (state_q == S_FETCH);
  assign instr_valid     = (state_q == S_EXEC);
  assign imem_addr       = pc_q;
  assign pc_out          = pc_q;
  assign pc_plus4        = pc_q + XLEN'(PC_STEP);
  assign instr_out       = instr_q;
  assign misaligned_trap = trap_q;
  assign trap_pc         = trap_pc_q;
  assign retire_count    = retire_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

- Owns the program counter and the instruction-fetch handshake to instruction memory.
- Sits directly downstream of the branch unit: consumes its `PCSrc` decision, together with the jump and target signals, to choose the next PC.
- Sequences each instruction as fetch (wait for memory) → execute (hold the instruction stable for the datapath), and halts on a misaligned control-flow target.

## Interface
Parameters:
- `XLEN`, 32, address/PC width.
- `RESET_PC`, 32'h0000_0000, PC after reset; must be word-aligned (elaboration-time assertion).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PCSrc`  in  1  branch-taken from branch unit; sampled only in S_EXEC.
- `jump`  in  1  jal/jalr taken; priority over `PCSrc`.
- `branch_target`  in  XLEN  PC-relative branch target.
- `jump_target`  in  XLEN  jal/jalr target (jalr LSB already cleared upstream).
- `stall`  in  1  hold current instruction in S_EXEC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  XLEN  fetch address (= `pc_out`).
- `imem_ready`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_out`  out  32  registered instruction to decode.
- `instr_valid`  out  1  `instr_out`/`pc_out` valid for execution.
- `pc_out`  out  XLEN  current PC.
- `pc_plus4`  out  XLEN  `pc_out + 4` (combinational, for jal link).
- `misaligned_trap`  out  1  sticky: redirect target not word-aligned.
- `trap_pc`  out  XLEN  offending target address.
- `retire_count`  out  32  instructions retired.

## Operation
- States: S_RESET, S_FETCH, S_EXEC, S_HALT.
- **S_RESET**
  - Entered on reset; lasts exactly one cycle after `reset` deasserts.
  - No request issued; moves to S_FETCH.
- **S_FETCH**
  - `imem_req=1`, `imem_addr=pc`.
  - On `imem_ready=1`: latch `imem_rdata` into the instruction register and go to S_EXEC; otherwise remain.
- **S_EXEC**
  - `instr_valid=1`.
  - If `stall=1`: remain, with PC and instruction unchanged.
  - Otherwise compute next PC, in priority order:
    - `jump` → `jump_target`;
    - `PCSrc` → `branch_target`;
    - else `pc+4`.
  - If next PC is word-aligned (`[1:0]==0`):
    - load PC;
    - increment `retire_count`;
    - go to S_FETCH.
  - If next PC is misaligned:
    - set `misaligned_trap=1` and `trap_pc`=next PC;
    - increment `retire_count`;
    - go to S_HALT; PC is not updated.
- **S_HALT**: absorbing until reset; `imem_req=0`, `instr_valid=0`.
- **Arithmetic**
  - `pc+4` is modulo 2^XLEN: 0xFFFF_FFFC wraps to 0.
  - `retire_count` wraps from 0xFFFF_FFFF to 0.
- `imem_ready` outside S_FETCH is ignored.
- `PCSrc`, `jump` and the targets are don't-care outside S_EXEC.

## Timing
- Reset values:
  - pc=`RESET_PC`, state=S_RESET;
  - `instr_out`=32'h0000_0013 (NOP);
  - `instr_valid=0`, `imem_req=0`;
  - `misaligned_trap=0`, `trap_pc=0`;
  - `retire_count=0`.
- Reset asserted mid-operation (any state, including mid-fetch): all of the above take effect immediately and asynchronously; any pending memory response is dropped.
- Zero-wait memory: 2 cycles per instruction (S_FETCH 1, S_EXEC 1); each memory wait cycle adds 1.
- Outputs:
  - `imem_req`, `instr_valid`: decoded from the state register only (no input-to-output combinational path).
  - `imem_addr`, `pc_out`, `instr_out`: registered.
  - `pc_plus4`: combinational from `pc_out`.
- Redirect takes effect at the S_EXEC→S_FETCH edge; the next `imem_addr` is the new PC.
- `stall` and redirect in the same cycle: stall wins; the redirect is re-evaluated next cycle.

## Structure
- Package `fetch_pkg` holds:
  - the `fetch_state_t` enum (S_RESET, S_FETCH, S_EXEC, S_HALT);
  - `NOP_INSTR` = 32'h0000_0013;
  - the `PC_STEP` constant (4).
- One combinational sub-module, `next_pc_sel`. It takes `jump`, `PCSrc`, both targets and `pc`; it produces the next PC and a misaligned flag.
- The FSM, PC register, instruction register and counter live in `fetch_pc_unit`.

## Test plan
- **Reset/sequential fetch**: reset released, `imem_ready` tied 1.
  - `imem_addr` = 0x0, 0x4, 0x8 on successive S_FETCH cycles.
  - `retire_count` = 3 after three S_EXEC cycles.
- **Memory wait**: hold `imem_ready=0` for 3 cycles at PC 0x10.
  - `imem_req` stays 1 and `instr_valid` stays 0.
  - Instruction latched on the 4th cycle; `instr_valid=1` the next cycle.
- **Redirect priority**: in S_EXEC at PC 0x20, set `jump=1`, `PCSrc=1`, `jump_target`=0x100, `branch_target`=0x40.
  - Next `imem_addr`=0x100.
  - With `jump=0`: next `imem_addr`=0x40.
- **Stall**: `stall=1` for 2 cycles in S_EXEC at PC 0x30 with `PCSrc=1`.
  - PC, `instr_out` and `retire_count` are unchanged.
  - On release: fetch from `branch_target`.
- **Misaligned**: `branch_target`=0x102, `PCSrc=1`.
  - `misaligned_trap=1`, `trap_pc`=0x102; `pc_out` unchanged.
  - `imem_req` stays 0 until reset.
- **Wrap/reset mid-fetch**: PC 0xFFFF_FFFC, no branch → next `imem_addr`=0x0.
  - Assert `reset` while `imem_req=1`: outputs return to reset values in the same cycle.
